// File: rtl/bus_burst_target.sv
// Burst-capable bus responder that owns a single-port word RAM shared with a local pixel port.
// The local port always wins the RAM; a bus beat that collides with it is stalled through busyOut.
module bus_burst_target #(
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 beginTransactionIn,
  input  logic [31:0]          addressDataIn,
  input  logic                 readNotWriteIn,
  input  logic [3:0]           byteEnablesIn,
  input  logic [7:0]           burstSizeIn,
  input  logic                 dataValidIn,
  input  logic                 endTransactionIn,
  output logic [31:0]          addressDataOut,
  output logic                 dataValidOut,
  output logic                 endTransactionOut,
  output logic                 busyOut,
  output logic                 busErrorOut,
  input  logic                 localEnable,
  input  logic                 localWrite,
  input  logic [ADDR_BITS-1:0] localAddress,
  input  logic [31:0]          localDataIn,
  output logic [31:0]          localDataOut
);

  localparam int unsigned TAG_LSB = ADDR_BITS + 2;
  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_WAIT,
    S_READ_DATA,
    S_READ_END,
    S_ERROR_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [3:0]           be_q, be_d;
  logic                 err_q, err_d;
  logic [31:0]          bus_rd_q;
  logic [31:0]          local_rd_q;
  logic [31:0]          mem [DEPTH];

  logic hit_s;
  logic busy_s;
  logic dv_s;
  logic bus_rd_s;
  logic bus_wr_s;

  assign hit_s = (addressDataIn[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

  // Next-state logic; a cycle that collides with the local port changes nothing but busy.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    be_d     = be_q;
    err_d    = 1'b0;
    busy_s   = 1'b0;
    dv_s     = 1'b0;
    bus_rd_s = 1'b0;
    bus_wr_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (beginTransactionIn && hit_s) begin
          ptr_d = addressDataIn[TAG_LSB-1:2];
          be_d  = byteEnablesIn;
          cnt_d = {1'b0, burstSizeIn} + 9'd1;
          if (byteEnablesIn == 4'h0) begin
            err_d   = 1'b1;
            state_d = S_ERROR_DRAIN;
          end else if (readNotWriteIn) begin
            state_d = S_READ_WAIT;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (dataValidIn && localEnable) begin
          busy_s = 1'b1;
        end else begin
          if (dataValidIn && (cnt_q != 9'd0)) begin
            bus_wr_s = 1'b1;
            ptr_d    = ptr_q + PTR_ONE;
            cnt_d    = cnt_q - 9'd1;
          end else begin
            bus_wr_s = 1'b0;
          end
          // Closing with beats still owed drops them and flags the initiator.
          if (endTransactionIn) begin
            state_d = S_IDLE;
            err_d   = (cnt_d != 9'd0);
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ_WAIT: begin
        if (localEnable) begin
          busy_s = 1'b1;
        end else begin
          bus_rd_s = 1'b1;
          ptr_d    = ptr_q + PTR_ONE;
          state_d  = S_READ_DATA;
        end
      end
      S_READ_DATA: begin
        if (localEnable) begin
          busy_s = 1'b1;
        end else begin
          dv_s  = 1'b1;
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_READ_END;
          end else begin
            bus_rd_s = 1'b1;
            ptr_d    = ptr_q + PTR_ONE;
          end
        end
      end
      S_READ_END: begin
        state_d = S_IDLE;
      end
      S_ERROR_DRAIN: begin
        if (endTransactionIn) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ERROR_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Transaction state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= 9'd0;
      be_q    <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  // RAM write port: local side first, otherwise a masked bus beat.
  always_ff @(posedge clock) begin
    if (localEnable) begin
      if (localWrite) begin
        mem[localAddress] <= localDataIn;
      end
    end else if (bus_wr_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[ptr_q][8*b +: 8] <= addressDataIn[8*b +: 8];
        end
      end
    end
  end

  // Separate read registers so a local read never clobbers a pending bus beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus_rd_q   <= 32'h0;
      local_rd_q <= 32'h0;
    end else begin
      if (localEnable && !localWrite) begin
        local_rd_q <= mem[localAddress];
      end
      if (bus_rd_s) begin
        bus_rd_q <= mem[ptr_q];
      end
    end
  end

  assign addressDataOut    = dv_s ? bus_rd_q : 32'h0;
  assign dataValidOut      = dv_s;
  assign endTransactionOut = (state_q == S_READ_END);
  assign busyOut           = busy_s;
  assign busErrorOut       = err_q;
  assign localDataOut      = local_rd_q;

endmodule

// File: tb/tb_bus_burst_target.sv
// Directed bench for bus_burst_target: a table of single-word write/read vectors plus
// hand-written sequences for bursts, wrap, local-port conflicts, errors and reset.
module tb_bus_burst_target;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic        readNotWriteIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyOut;
  logic        busErrorOut;
  logic        localEnable;
  logic        localWrite;
  logic [7:0]  localAddress;
  logic [31:0] localDataIn;
  logic [31:0] localDataOut;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q [0:7];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pre;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  bus_burst_target #(.BASE_ADDR(BASE), .ADDR_BITS(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn     (addressDataIn),
    .readNotWriteIn    (readNotWriteIn),
    .byteEnablesIn     (byteEnablesIn),
    .burstSizeIn       (burstSizeIn),
    .dataValidIn       (dataValidIn),
    .endTransactionIn  (endTransactionIn),
    .addressDataOut    (addressDataOut),
    .dataValidOut      (dataValidOut),
    .endTransactionOut (endTransactionOut),
    .busyOut           (busyOut),
    .busErrorOut       (busErrorOut),
    .localEnable       (localEnable),
    .localWrite        (localWrite),
    .localAddress      (localAddress),
    .localDataIn       (localDataIn),
    .localDataOut      (localDataOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be, input int nbeats,
                           input int nsend, input logic [31:0] d0, input logic exp_err);
    int guard;
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    readNotWriteIn     = 1'b0;
    byteEnablesIn      = be;
    burstSizeIn        = 8'(nbeats - 1);
    cyc();
    beginTransactionIn = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      dataValidIn      = 1'b1;
      addressDataIn    = d0 + 32'(i);
      endTransactionIn = (i == nsend - 1);
      guard = 0;
      #2;
      while (busyOut && guard < 20) begin
        cyc();
        #2;
        guard++;
      end
      if (guard >= 20) check("wr_stall_bound", 32'(guard), 32'd0);
      cyc();
    end
    dataValidIn      = 1'b0;
    endTransactionIn = 1'b0;
    addressDataIn    = 32'h0;
    #2;
    check("wr_err", {31'd0, busErrorOut}, {31'd0, exp_err});
    cyc();
  endtask

  task automatic bus_read(input string nm, input logic [31:0] addr, input int nbeats,
                          input int conflict_at, output int end_cycle);
    int got;
    int last_beat;
    bit done;
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    readNotWriteIn     = 1'b1;
    byteEnablesIn      = 4'hF;
    burstSizeIn        = 8'(nbeats - 1);
    cyc();
    beginTransactionIn = 1'b0;
    addressDataIn      = 32'h0;
    readNotWriteIn     = 1'b0;
    got = 0;
    last_beat = -1;
    end_cycle = -1;
    done = 1'b0;
    for (int c = 1; c < 40 && !done; c++) begin
      localEnable  = (c == conflict_at);
      localWrite   = 1'b0;
      localAddress = 8'd0;
      #2;
      if (c == conflict_at) begin
        check({nm, "_conf_busy"}, {31'd0, busyOut}, 32'd1);
        check({nm, "_conf_dv"}, {31'd0, dataValidOut}, 32'd0);
      end
      if (dataValidOut) begin
        if (got < nbeats) check({nm, "_data"}, addressDataOut, exp_q[got]);
        else check({nm, "_extra_beat"}, 32'(got + 1), 32'(nbeats));
        if (got == 0) check({nm, "_latency"}, 32'(c), 32'd2);
        got++;
        last_beat = c;
      end
      if (endTransactionOut) begin
        check({nm, "_beats"}, 32'(got), 32'(nbeats));
        check({nm, "_end_gap"}, 32'(c), 32'(last_beat + 1));
        end_cycle = c;
        done = 1'b1;
      end
      cyc();
    end
    localEnable = 1'b0;
    check({nm, "_end_seen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec;
    vecs[0] = '{BASE + 32'h10,  32'h0000_0000, 32'hDEAD_BEEF, 4'hF, BASE + 32'h10,  32'hDEAD_BEEF};
    vecs[1] = '{BASE + 32'h20,  32'h1122_3344, 32'hAABB_CCDD, 4'h5, BASE + 32'h20,  32'h11BB_33DD};
    vecs[2] = '{BASE + 32'h24,  32'h1122_3344, 32'hAABB_CCDD, 4'hA, BASE + 32'h24,  32'hAA22_CC44};
    vecs[3] = '{BASE + 32'h2B,  32'h0000_0000, 32'h1234_5678, 4'hF, BASE + 32'h28,  32'h1234_5678};
    vecs[4] = '{BASE + 32'h3FC, 32'hFFFF_FFFF, 32'h0000_0000, 4'h8, BASE + 32'h3FC, 32'h00FF_FFFF};

    reset = 1'b0;
    beginTransactionIn = 1'b0; addressDataIn = 32'h0; readNotWriteIn = 1'b0;
    byteEnablesIn = 4'h0; burstSizeIn = 8'd0; dataValidIn = 1'b0; endTransactionIn = 1'b0;
    localEnable = 1'b0; localWrite = 1'b0; localAddress = 8'd0; localDataIn = 32'h0;
    repeat (3) cyc();
    #2;
    check("reset_outputs", {dataValidOut, endTransactionOut, busyOut, busErrorOut}, 4'h0);
    check("reset_data", addressDataOut, 32'h0);
    check("reset_local", localDataOut, 32'h0);
    reset = 1'b1;
    cyc();

    // Table-driven single-word vectors: preload, masked write, read back.
    for (int v = 0; v < 5; v++) begin
      bus_write(vecs[v].addr, 4'hF, 1, 1, vecs[v].pre, 1'b0);
      bus_write(vecs[v].addr, vecs[v].be, 1, 1, vecs[v].wdata, 1'b0);
      exp_q[0] = vecs[v].exp;
      bus_read($sformatf("vec%0d", v), vecs[v].raddr, 1, -1, ec);
      check($sformatf("vec%0d_end_cycle", v), 32'(ec), 32'd3);
    end

    // Burst across the top of the RAM wraps to word 0.
    bus_write(BASE + 32'h3F8, 4'hF, 4, 4, 32'd1, 1'b0);
    exp_q[0] = 32'd1; exp_q[1] = 32'd2; exp_q[2] = 32'd3; exp_q[3] = 32'd4;
    bus_read("burst_wrap", BASE + 32'h3F8, 4, -1, ec);
    check("burst_wrap_end_cycle", 32'(ec), 32'd6);
    exp_q[0] = 32'd3;
    bus_read("wrap_w0", BASE, 1, -1, ec);
    exp_q[0] = 32'd4;
    bus_read("wrap_w1", BASE + 32'h4, 1, -1, ec);

    // Local read stalls the second beat of a three-beat read by one cycle.
    exp_q[0] = 32'd2; exp_q[1] = 32'd3; exp_q[2] = 32'd4;
    bus_read("conf_read", BASE + 32'h3FC, 3, 3, ec);
    check("conf_read_end_cycle", 32'(ec), 32'd6);

    // Local and bus write the same word in the same cycle; bus lands last.
    beginTransactionIn = 1'b1; addressDataIn = BASE + 32'hC8; readNotWriteIn = 1'b0;
    byteEnablesIn = 4'hF; burstSizeIn = 8'd0;
    cyc();
    beginTransactionIn = 1'b0;
    dataValidIn = 1'b1; addressDataIn = 32'd2; endTransactionIn = 1'b1;
    localEnable = 1'b1; localWrite = 1'b1; localAddress = 8'd50; localDataIn = 32'd1;
    #2;
    check("conf_wr_busy", {31'd0, busyOut}, 32'd1);
    cyc();
    localEnable = 1'b0; localWrite = 1'b0;
    #2;
    check("conf_wr_release", {31'd0, busyOut}, 32'd0);
    cyc();
    dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = 32'h0;
    #2;
    check("conf_wr_err", {31'd0, busErrorOut}, 32'd0);
    cyc();
    exp_q[0] = 32'd2;
    bus_read("conf_wr_bus", BASE + 32'hC8, 1, -1, ec);
    localEnable = 1'b1; localWrite = 1'b0; localAddress = 8'd50;
    cyc();
    localEnable = 1'b0;
    #2;
    check("conf_wr_local", localDataOut, 32'd2);
    cyc();

    // Local write then local read and bus read of the same word.
    localEnable = 1'b1; localWrite = 1'b1; localAddress = 8'd40; localDataIn = 32'hCAFE_0001;
    cyc();
    localWrite = 1'b0;
    cyc();
    localEnable = 1'b0;
    #2;
    check("local_rd", localDataOut, 32'hCAFE_0001);
    cyc();
    exp_q[0] = 32'hCAFE_0001;
    bus_read("local_bus_rd", BASE + 32'hA0, 1, -1, ec);

    // Outside the window: no response, and nothing written to the aliased word.
    beginTransactionIn = 1'b1; addressDataIn = BASE + 32'h1000; readNotWriteIn = 1'b1;
    byteEnablesIn = 4'hF; burstSizeIn = 8'd0;
    cyc();
    beginTransactionIn = 1'b0; readNotWriteIn = 1'b0; addressDataIn = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("miss_rd_quiet", {dataValidOut, endTransactionOut, busyOut, busErrorOut}, 4'h0);
      cyc();
    end
    bus_write(BASE + 32'h1000, 4'hF, 1, 1, 32'h0000_0BAD, 1'b0);
    exp_q[0] = 32'd3;
    bus_read("miss_wr_noalias", BASE, 1, -1, ec);

    // Zero byte enables: one-cycle error pulse, beats drained, RAM untouched.
    bus_write(BASE + 32'h14, 4'hF, 1, 1, 32'h55, 1'b0);
    beginTransactionIn = 1'b1; addressDataIn = BASE + 32'h14; readNotWriteIn = 1'b0;
    byteEnablesIn = 4'h0; burstSizeIn = 8'd0;
    cyc();
    beginTransactionIn = 1'b0;
    dataValidIn = 1'b1; addressDataIn = 32'hFFFF_FFFF;
    #2;
    check("be0_err_pulse", {31'd0, busErrorOut}, 32'd1);
    cyc();
    endTransactionIn = 1'b1;
    #2;
    check("be0_err_single", {31'd0, busErrorOut}, 32'd0);
    cyc();
    dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = 32'h0;
    exp_q[0] = 32'h55;
    bus_read("be0_ram", BASE + 32'h14, 1, -1, ec);

    // Early end after 1 of 4 beats.
    bus_write(BASE + 32'h50, 4'hF, 1, 1, 32'hA0, 1'b0);
    bus_write(BASE + 32'h54, 4'hF, 1, 1, 32'hA1, 1'b0);
    bus_write(BASE + 32'h50, 4'hF, 4, 1, 32'h77, 1'b1);
    exp_q[0] = 32'h77; exp_q[1] = 32'hA1;
    bus_read("early_end", BASE + 32'h50, 2, -1, ec);

    // Beats past the burst length are ignored.
    bus_write(BASE + 32'h78, 4'hF, 1, 1, 32'h30, 1'b0);
    bus_write(BASE + 32'h7C, 4'hF, 1, 1, 32'h31, 1'b0);
    bus_write(BASE + 32'h78, 4'hF, 1, 2, 32'hC0, 1'b0);
    exp_q[0] = 32'hC0; exp_q[1] = 32'h31;
    bus_read("overrun", BASE + 32'h78, 2, -1, ec);

    // Reset during the second beat of a four-beat read.
    beginTransactionIn = 1'b1; addressDataIn = BASE + 32'h3F8; readNotWriteIn = 1'b1;
    byteEnablesIn = 4'hF; burstSizeIn = 8'd3;
    cyc();
    beginTransactionIn = 1'b0; addressDataIn = 32'h0; readNotWriteIn = 1'b0;
    cyc();
    #2;
    check("rst_mid_beat0", addressDataOut, 32'd1);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    #2;
    check("rst_mid_outputs", {dataValidOut, endTransactionOut, busyOut, busErrorOut}, 4'h0);
    check("rst_mid_data", addressDataOut, 32'h0);
    check("rst_mid_local", localDataOut, 32'h0);
    cyc();
    exp_q[0] = 32'd1; exp_q[1] = 32'd2; exp_q[2] = 32'd3; exp_q[3] = 32'd4;
    bus_read("after_rst", BASE + 32'h3F8, 4, -1, ec);
    check("after_rst_end_cycle", 32'(ec), 32'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_burst_target.md
Name: bus_burst_target

Overview:
- Burst-capable bus responder (slave) for the shared system bus that accelerators master with begin/address-data/end/byte-enable/burst-size signalling.
- Owns a single-port word SRAM (frame/line scratch) decoded at a fixed base address.
- Serves single and burst reads and writes from bus initiators.
- A local pixel-side port shares the RAM and always has priority; conflicts throttle the bus with busyOut.

Parameters:
- BASE_ADDR, 32'h5000_0000, byte base of decoded window (aligned to window size)
- ADDR_BITS, 8, log2 of RAM depth in 32-bit words (256 words = 1 KiB window)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- beginTransactionIn  in  1  initiator starts a transaction; addressDataIn holds byte address
- addressDataIn  in  32  address on begin cycle, write data on data beats
- readNotWriteIn  in  1  sampled on begin: 1 = read, 0 = write
- byteEnablesIn  in  4  sampled on begin, applied to every write beat
- burstSizeIn  in  8  sampled on begin: beats minus one
- dataValidIn  in  1  write data beat valid
- endTransactionIn  in  1  initiator closes a write transaction
- addressDataOut  out  32  read data; 0 when dataValidOut=0
- dataValidOut  out  1  read data beat valid
- endTransactionOut  out  1  one-cycle pulse closing a read
- busyOut  out  1  target stall; a beat is not consumed/produced while high
- busErrorOut  out  1  one-cycle pulse on an erroneous transaction
- localEnable  in  1  local RAM access this cycle
- localWrite  in  1  1 = local write
- localAddress  in  ADDR_BITS  local word address
- localDataIn  in  32  local write data
- localDataOut  out  32  local read data, valid 1 cycle after a localEnable read

Behaviour:
- Reset (reset=0 at a clock edge):
  - all outputs 0; FSM to IDLE; any transaction in flight is abandoned.
  - RAM contents are not cleared.
- Address decode: hit when addressDataIn[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]. Word pointer = addressDataIn[ADDR_BITS+1:2]; bits [1:0] are ignored.
- FSM states: IDLE, WRITE, READ_WAIT, READ_DATA, READ_END, ERROR_DRAIN.
- IDLE, on beginTransactionIn:
  - miss: no response; stay IDLE.
  - hit, readNotWrite=0: capture pointer, byte enables and beat count = burstSizeIn+1; go to WRITE.
  - hit, readNotWrite=1: go to READ_WAIT.
  - hit with byteEnablesIn == 0: busErrorOut pulses the next cycle; go to ERROR_DRAIN.
- WRITE:
  - Each cycle with dataValidIn=1 and busyOut=0 writes addressDataIn to RAM[pointer], masked per byte by byteEnablesIn.
  - After each consumed beat: pointer += 1 (wraps modulo 2^ADDR_BITS); count -= 1.
  - Beats arriving after count reaches 0 are ignored.
  - endTransactionIn returns the FSM to IDLE, including the cycle it arrives with a final beat.
  - If endTransactionIn arrives with beats still outstanding, remaining beats are dropped and busErrorOut pulses 1 cycle.
- READ_WAIT: issue RAM read of pointer (one cycle of sync-RAM latency).
- READ_DATA:
  - Drive dataValidOut=1 with RAM data; first beat appears exactly 2 cycles after the begin cycle when no conflict occurs.
  - One beat per cycle; pointer wraps as for writes.
  - After burstSizeIn+1 beats, go to READ_END.
- READ_END: endTransactionOut=1 for 1 cycle, then IDLE.
- ERROR_DRAIN: ignore all beats until endTransactionIn, then IDLE.
- Conflict with the local port:
  - localEnable=1 in any cycle where the bus FSM would access RAM (WRITE with dataValidIn, READ_WAIT, READ_DATA) asserts busyOut combinationally that cycle.
  - The bus access is not performed; pointer and count hold.
  - In READ_DATA, dataValidOut=0 that cycle and the pending beat re-issues when the local port is idle.
  - busyOut is never asserted in IDLE or READ_END.
- Simultaneous local and bus write to the same word: the local write wins. The bus beat is stalled, then lands afterwards, so the bus value is final.
- beginTransactionIn outside IDLE is ignored (single outstanding transaction).

Test Plan:
- Single write then read: write 32'hDEADBEEF to BASE+0x10, byteEnables=4'hF, burstSize=0; read back the same address -> dataValidOut high exactly 2 cycles after begin with 32'hDEADBEEF, endTransactionOut 1 cycle after that beat.
- Burst wrap: write 4 beats 1,2,3,4 starting at word 254 (ADDR_BITS=8) -> words 254,255,0,1 hold 1,2,3,4; a 4-beat read from word 254 returns 1,2,3,4 in order.
- Byte enables: preload 32'h11223344, then write 32'hAABBCCDD with byteEnables=4'b0101 -> readback 32'h11BB33DD.
- Local conflict:
  - Case 1: localEnable=1 on the 2nd beat of a 3-beat read -> busyOut=1 and dataValidOut=0 that cycle; all 3 correct beats still delivered, total read latency +1 cycle.
  - Case 2: local write of 32'h1 and bus beat 32'h2 target the same word in the same cycle -> word finally reads 32'h2.
- Errors:
  - Address BASE+0x1000 -> no response.
  - byteEnables=0 -> busErrorOut 1-cycle pulse and RAM unchanged.
  - endTransactionIn after 1 of 4 write beats -> busErrorOut pulse and only the first word written.
- Reset mid-burst: reset=0 during the 2nd beat of a 4-beat read -> next cycle all outputs 0 and FSM IDLE; a subsequent read works normally.
